// File: rtl/rom_load_sched_pkg.sv
// rtl/rom_load_sched_pkg.sv - region map, FSM states and reference checksums for the ROM loader
package dk3_load_pkg;

  typedef enum logic [2:0] {
    RG_MAIN   = 3'd0,
    RG_SUB1   = 3'd1,
    RG_SUB2   = 3'd2,
    RG_TILE   = 3'd3,
    RG_SPRITE = 3'd4,
    RG_PROM   = 3'd5
  } region_t;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;

  localparam int NUM_REGIONS = 6;

  localparam logic [24:0] REGION_BASE [NUM_REGIONS] =
    '{25'h0000, 25'h6000, 25'h8000, 25'hA000, 25'hC000, 25'hE000};
  localparam logic [24:0] REGION_SIZE [NUM_REGIONS] =
    '{25'h6000, 25'h2000, 25'h2000, 25'h2000, 25'h2000, 25'h0400};

  // Modulo-256 byte sums of a known-good image, one per region.
  localparam logic [7:0] EXP_CHKSUM [NUM_REGIONS] =
    '{8'h3C, 8'hA7, 8'h51, 8'hE2, 8'h9D, 8'h0F};

  typedef struct packed {
    logic        hit;
    region_t     region;
    logic [15:0] offset;
  } map_hit_t;

  // Linear download address -> region code and region-relative offset.
  function automatic map_hit_t map_decode(input logic [24:0] addr);
    map_hit_t   r;
    logic [2:0] code;
    r = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      code = 3'(i);
      if (addr >= REGION_BASE[i] && addr < REGION_BASE[i] + REGION_SIZE[i]) begin
        r.hit    = 1'b1;
        r.region = region_t'(code);
        r.offset = 16'(addr - REGION_BASE[i]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_load_sched_if.sv
// rtl/rom_load_sched_if.sv - shared valid/ready write port toward the ROM targets
interface rom_load_sched_if;
  import dk3_load_pkg::*;

  logic        wr_valid;
  logic        wr_ready;
  region_t     wr_region;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (output wr_valid, output wr_region, output wr_addr, output wr_data,
                  input wr_ready);
  modport slave  (input wr_valid, input wr_region, input wr_addr, input wr_data,
                  output wr_ready);
endinterface

// File: rtl/rom_load_sched_load_fifo.sv
// rtl/rom_load_sched_load_fifo.sv - small byte FIFO with look-ahead of the next head entry
module load_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_next,
  output logic                       nonempty_next
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_idx;
  logic [CW-1:0]    count_next, remain;

  // storage write; contents need no reset because count gates every read
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointer and occupancy update
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // entry that will sit at the head after this edge, bypassing din when the FIFO runs dry
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    rd_idx        = pop ? rd_ptr + AW'(1) : rd_ptr;
    remain        = pop ? count - CW'(1) : count;
    head_next     = (remain == '0) ? din : mem[rd_idx];
    nonempty_next = (count_next != '0);
  end

  a_no_overflow: assert property (@(posedge clk_sys) disable iff (reset)
    !(push && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk_sys) disable iff (reset)
    !(pop && count == '0));

endmodule

// File: rtl/rom_load_sched.sv
// rtl/rom_load_sched.sv - ioctl download sequencer and core reset owner; ROM_LOAD_CHKSUM_EN adds per-region checksums
module rom_load_sched
  import dk3_load_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int DIP_BYTES   = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  output logic                   ioctl_wait,
  rom_load_sched_if.master       wport,
  output logic [8*DIP_BYTES-1:0] dip_sw,
  output logic                   core_reset,
  output logic                   load_done,
  output logic                   load_err
`ifdef ROM_LOAD_CHKSUM_EN
  ,
  output logic [8*NUM_REGIONS-1:0] chksum
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t        state, state_next;
  logic          download_q;
  logic [HW-1:0] hold_cnt;
  map_hit_t      map;
  logic          is_rom, push, pop, dl_rise, out_of_map, chk_fail;
  logic          nonempty_next;
  logic [CW-1:0] fifo_count;
  logic [26:0]   head_next;

  assign map        = map_decode(ioctl_addr);
  assign is_rom     = (ioctl_index == 8'd0);
  assign push       = ioctl_wr & is_rom & map.hit;
  assign out_of_map = ioctl_wr & is_rom & ~map.hit;
  assign pop        = wport.wr_valid & wport.wr_ready;
  assign dl_rise    = ioctl_download & ~download_q & is_rom;
  assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1));

  load_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(27)) u_fifo (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .push          (push),
    .pop           (pop),
    .din           ({map.region, map.offset, ioctl_dout}),
    .count         (fifo_count),
    .head_next     (head_next),
    .nonempty_next (nonempty_next)
  );

  // FSM state register plus download edge tracking
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      download_q <= 1'b0;
    end else begin
      state      <= state_next;
      download_q <= ioctl_download;
    end
  end

  // next state; DRAIN leaves on the edge that retires the last queued byte
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dl_rise) state_next = LOAD;
      LOAD:    if (!ioctl_download) state_next = DRAIN;
      DRAIN:   if (!nonempty_next) state_next = HOLD;
      HOLD:    if (hold_cnt == '0) state_next = RUN;
      RUN:     if (dl_rise) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // the core only runs once an image is in place and has settled
  always_comb begin
    core_reset = (state != RUN);
    load_done  = (state == RUN);
  end

  // settle counter, armed on entry to HOLD
  always_ff @(posedge clk_sys) begin
    if (reset)                                     hold_cnt <= '0;
    else if (state != HOLD && state_next == HOLD) hold_cnt <= HOLD_LOAD;
    else if (state == HOLD && hold_cnt != '0)     hold_cnt <= hold_cnt - HW'(1);
  end

  // output stage: present the next head whenever the current beat is absent or accepted
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wport.wr_valid  <= 1'b0;
      wport.wr_region <= RG_MAIN;
      wport.wr_addr   <= '0;
      wport.wr_data   <= '0;
    end else if (!wport.wr_valid || wport.wr_ready) begin
      wport.wr_valid <= nonempty_next;
      if (nonempty_next) begin
        wport.wr_region <= region_t'(head_next[26:24]);
        wport.wr_addr   <= head_next[23:8];
        wport.wr_data   <= head_next[7:0];
      end
    end
  end

  // DIP bank bytes land directly, never through the FIFO
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dip_sw <= '1;
    end else if (ioctl_wr && ioctl_index == 8'd254) begin
      for (int n = 0; n < DIP_BYTES; n++)
        if (ioctl_addr == 25'(n)) dip_sw[8*n +: 8] <= ioctl_dout;
    end
  end

`ifdef ROM_LOAD_CHKSUM_EN
  logic [NUM_REGIONS-1:0][7:0] sum_q;
  logic                        sum_bad;

  // per-region running sum of retired bytes, restarted for each new load
  always_ff @(posedge clk_sys) begin
    if (reset || (state != LOAD && state_next == LOAD)) sum_q <= '0;
    else if (pop) sum_q[wport.wr_region] <= sum_q[wport.wr_region] + wport.wr_data;
  end

  // any region disagreeing with its reference sum
  always_comb begin
    sum_bad = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (sum_q[i] != EXP_CHKSUM[i]) sum_bad = 1'b1;
  end

  assign chksum   = sum_q;
  assign chk_fail = (state == HOLD) && (hold_cnt == HOLD_LOAD) && sum_bad;
`else
  assign chk_fail = 1'b0;
`endif

  // sticky error, cleared only by reset
  always_ff @(posedge clk_sys) begin
    if (reset)                      load_err <= 1'b0;
    else if (out_of_map || chk_fail) load_err <= 1'b1;
  end

endmodule

// File: tb/tb_rom_load_sched.sv
// tb/tb_rom_load_sched.sv - scoreboard bench for the ROM download sequencer
module tb_rom_load_sched;
  import dk3_load_pkg::*;

  localparam int HOLD_CYCLES = 1024;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait;
  logic [63:0] dip_sw;
  logic        core_reset, load_done, load_err;
`ifdef ROM_LOAD_CHKSUM_EN
  logic [47:0] chksum;
`endif

  always #20 clk_sys = ~clk_sys;

  rom_load_sched_if wr_if();

  rom_load_sched #(.FIFO_DEPTH(4), .HOLD_CYCLES(HOLD_CYCLES), .DIP_BYTES(8)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .wport          (wr_if),
    .dip_sw         (dip_sw),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .load_err       (load_err)
`ifdef ROM_LOAD_CHKSUM_EN
    ,
    .chksum         (chksum)
`endif
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          n_beats = 0;
  logic [26:0] sb[$];
  logic        was_stalled = 1'b0;
  logic [26:0] held = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] exp_entry(input logic [24:0] a, input logic [7:0] d);
    logic [2:0]  r;
    logic [24:0] base;
    if (a < 25'h6000)      begin r = 3'd0; base = 25'h0000; end
    else if (a < 25'h8000) begin r = 3'd1; base = 25'h6000; end
    else if (a < 25'hA000) begin r = 3'd2; base = 25'h8000; end
    else if (a < 25'hC000) begin r = 3'd3; base = 25'hA000; end
    else if (a < 25'hE000) begin r = 3'd4; base = 25'hC000; end
    else                   begin r = 3'd5; base = 25'hE000; end
    return {r, 16'(a - base), d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    int guard = 0;
    while (ioctl_wait && guard < 200) begin
      tick(1);
      guard++;
    end
    check("wait_bound", ioctl_wait, 1'b0);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    if (idx == 8'd0 && addr < 25'hE400) sb.push_back(exp_entry(addr, data));
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !wr_if.wr_valid) break;
      tick(1);
    end
    check("drain", {sb.size() != 0, wr_if.wr_valid}, 2'b00);
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (reset) begin
      was_stalled <= 1'b0;
    end else begin
      if (was_stalled)
        check("stall_hold", {wr_if.wr_valid, wr_if.wr_region, wr_if.wr_addr, wr_if.wr_data},
              {1'b1, held});
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0)
          check("beat", {wr_if.wr_region, wr_if.wr_addr, wr_if.wr_data}, sb.pop_front());
        n_beats <= n_beats + 1;
        last_hs <= cyc + 1;
      end
      was_stalled <= wr_if.wr_valid & ~wr_if.wr_ready;
      held        <= {wr_if.wr_region, wr_if.wr_addr, wr_if.wr_data};
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [8];
    int         beats0;

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_index = '0;
    wr_if.wr_ready = 1'b1;
    tick(3);
    check("rst_wr_valid", wr_if.wr_valid, 1'b0);
    check("rst_wr_fields", {wr_if.wr_region, wr_if.wr_addr, wr_if.wr_data}, 27'd0);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_dip", dip_sw, {64{1'b1}});
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_load_done", load_done, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    reset = 1'b0;
    tick(2);

    // 1: four in-order bytes to the main CPU region
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick(1);
    beats0 = n_beats;
    for (int i = 0; i < 4; i++) send_byte(8'd0, 25'(i), 8'hA0 + 8'(i));
    wait_drain();
    check("t1_beats", n_beats - beats0, 4);
    check("t1_core_reset", core_reset, 1'b1);

    // 2: backpressure with the target stalled
    for (int i = 0; i < 8; i++) burst[i] = 8'($urandom);
    wr_if.wr_ready = 1'b0;
    send_byte(8'd0, 25'h10, burst[0]);
    send_byte(8'd0, 25'h11, burst[1]);
    check("t2_wait_at2", ioctl_wait, 1'b0);
    send_byte(8'd0, 25'h12, burst[2]);
    check("t2_wait_at3", ioctl_wait, 1'b1);
    fork
      begin
        for (int i = 3; i < 8; i++) send_byte(8'd0, 25'h10 + 25'(i), burst[i]);
      end
      begin
        tick(6);
        for (int k = 0; k < 20; k++) begin
          wr_if.wr_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
        wr_if.wr_ready = 1'b1;
      end
    join
    wait_drain();

    // 3: region boundaries and an out-of-map byte
    send_byte(8'd0, 25'h5FFF, 8'h11);
    send_byte(8'd0, 25'h6005, 8'h33);
    send_byte(8'd0, 25'hA000, 8'h44);
    send_byte(8'd0, 25'hE3FF, 8'h55);
    check("t3_err_clear", load_err, 1'b0);
    send_byte(8'd0, 25'hE400, 8'h66);
    check("t3_err_set", load_err, 1'b1);
    wait_drain();

    // 4: drain then settle hold before the core is released
    wr_if.wr_ready = 1'b0;
    send_byte(8'd0, 25'hC010, 8'h77);
    send_byte(8'd0, 25'h8001, 8'h88);
    ioctl_download = 1'b0;
    tick(3);
    check("t4_drain_reset", core_reset, 1'b1);
    wr_if.wr_ready = 1'b1;
    wait_drain();
    for (int i = 0; i < HOLD_CYCLES + 100; i++) begin
      if (!core_reset) break;
      tick(1);
    end
    check("t4_core_reset_fall", core_reset, 1'b0);
    check("t4_hold_len", cyc - last_hs, HOLD_CYCLES);
    check("t4_load_done", load_done, 1'b1);
    check("t4_err_sticky", load_err, 1'b1);

    // 5: DIP bank download leaves the running core alone
    ioctl_index = 8'd254;
    ioctl_download = 1'b1;
    tick(1);
    send_byte(8'd254, 25'd1, 8'h5A);
    send_byte(8'd254, 25'd8, 8'h00);
    ioctl_download = 1'b0;
    tick(2);
    check("t5_dip", dip_sw, 64'hFFFF_FFFF_FFFF_5AFF);
    check("t5_core_reset", core_reset, 1'b0);
    check("t5_load_done", load_done, 1'b1);

    // 6: reload, then reset with bytes still queued
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick(2);
    check("t6_reload_reset", core_reset, 1'b1);
    check("t6_reload_done", load_done, 1'b0);
    wr_if.wr_ready = 1'b0;
    send_byte(8'd0, 25'h0040, 8'h99);
    send_byte(8'd0, 25'h0041, 8'h9A);
    check("t6_pending", wr_if.wr_valid, 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick(1);
    sb.delete();
    check("t6_wr_valid", wr_if.wr_valid, 1'b0);
    check("t6_core_reset", core_reset, 1'b1);
    check("t6_wait", ioctl_wait, 1'b0);
    check("t6_dip", dip_sw, {64{1'b1}});
    check("t6_err", load_err, 1'b0);
    reset = 1'b0;
    wr_if.wr_ready = 1'b1;
    tick(2);
    check("t6_idle_valid", wr_if.wr_valid, 1'b0);
    check("t6_idle_core_reset", core_reset, 1'b1);

    // fresh load after the abort still works
    ioctl_download = 1'b1;
    tick(1);
    beats0 = n_beats;
    send_byte(8'd0, 25'h0100, 8'hC3);
    wait_drain();
    check("t6_fresh_beats", n_beats - beats0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
